iomem_gpio: RTL

//  Parametrised GPIO peripheral on the PicoSoC iomem bus; successor to the fixed 32-bit LED register.

---
 rtl/iomem_gpio_pkg.sv | 27 ++
 rtl/iomem_gpio_if.sv | 31 +++
 rtl/iomem_gpio_sync.sv | 26 ++
 rtl/iomem_gpio.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/iomem_gpio_pkg.sv
// Shared definitions for the iomem GPIO peripheral: bus width, register
// offsets (word index = iomem_addr[4:2]), polarity encoding and a byte-lane
// helper used by every RW register.
package iomem_gpio_pkg;

  localparam int BUS_W = 32;

  // Register word offsets
  localparam logic [2:0] GPIO_OUT      = 3'd0;
  localparam logic [2:0] GPIO_OE       = 3'd1;
  localparam logic [2:0] GPIO_IN       = 3'd2;
  localparam logic [2:0] GPIO_IRQ_EN   = 3'd3;
  localparam logic [2:0] GPIO_IRQ_STAT = 3'd4;
  localparam logic [2:0] GPIO_IRQ_POL  = 3'd5;
  localparam logic [2:0] GPIO_OUT_SET  = 3'd6;
  localparam logic [2:0] GPIO_OUT_CLR  = 3'd7;

  // IRQ_POL bit encoding
  localparam logic POL_FALL = 1'b0;
  localparam logic POL_RISE = 1'b1;

  // Expand the four byte strobes into a 32-bit bit mask.
  function automatic logic [BUS_W-1:0] lane_mask(input logic [3:0] wstrb);
    return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  endfunction

endpackage

// File: rtl/iomem_gpio_if.sv
// PicoSoC iomem bus bundle. The SoC side is the master; peripherals
// answer through the slave modport.
interface iomem_gpio_if;
  import iomem_gpio_pkg::*;

  logic             valid;
  logic             ready;
  logic [3:0]       wstrb;
  logic [BUS_W-1:0] addr;
  logic [BUS_W-1:0] wdata;
  logic [BUS_W-1:0] rdata;

  modport master (
    output valid,
    output wstrb,
    output addr,
    output wdata,
    input  ready,
    input  rdata
  );

  modport slave (
    input  valid,
    input  wstrb,
    input  addr,
    input  wdata,
    output ready,
    output rdata
  );

endinterface

// File: rtl/iomem_gpio_sync.sv
// Single-bit multi-flop synchroniser for an asynchronous pad input.
// The top instantiates one of these per pin as an instance array.
module iomem_gpio_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the pad value through the flop chain; the last flop is the
  // first one safe to use in the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/iomem_gpio.sv
// GPIO peripheral on the PicoSoC iomem bus: output/enable registers with
// atomic set/clear aliases, synchronised inputs, per-pin edge interrupts
// with a sticky write-one-to-clear status and one registered IRQ line.
module iomem_gpio
  import iomem_gpio_pkg::*;
#(
  parameter int         NUM_PINS    = 32,
  parameter logic [7:0] BASE_ADDR   = 8'h03,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  iomem_gpio_if.slave         bus,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oe,
  output logic                irq
);

  logic [NUM_PINS-1:0] irq_en;
  logic [NUM_PINS-1:0] irq_stat;
  logic [NUM_PINS-1:0] irq_pol;
  logic [NUM_PINS-1:0] sync;
  logic [NUM_PINS-1:0] prev;
  logic [NUM_PINS-1:0] rise;
  logic [NUM_PINS-1:0] fall;
  logic [NUM_PINS-1:0] edge_hit;
  logic [NUM_PINS-1:0] stat_clr;

  logic                hit;
  logic                wr;
  logic [2:0]          sel;
  logic [BUS_W-1:0]    wmask;
  logic [BUS_W-1:0]    wbits;
  logic [NUM_PINS-1:0] pin_mask;
  logic [NUM_PINS-1:0] pin_bits;
  logic [NUM_PINS-1:0] rd_pins;
  logic [BUS_W-1:0]    rd_word;

  // Address bits outside the decode/select fields, and data bits above
  // NUM_PINS, are deliberately ignored.
  logic                unused_bits;
  assign unused_bits = ^{bus.addr[23:5], bus.addr[1:0], wbits};

  // Byte-lane merge for the plain RW registers.
  function automatic logic [NUM_PINS-1:0] merge(input logic [NUM_PINS-1:0] old,
                                                input logic [NUM_PINS-1:0] mask,
                                                input logic [NUM_PINS-1:0] bits);
    return (old & ~mask) | bits;
  endfunction

  // A new request is only taken while no acknowledge is outstanding, so a
  // held valid is re-accepted at most every second cycle.
  assign hit      = bus.valid && !bus.ready && (bus.addr[31:24] == BASE_ADDR);
  assign wr       = hit && (bus.wstrb != 4'b0000);
  assign sel      = bus.addr[4:2];
  assign wmask    = lane_mask(bus.wstrb);
  assign wbits    = bus.wdata & wmask;
  assign pin_mask = wmask[NUM_PINS-1:0];
  assign pin_bits = wbits[NUM_PINS-1:0];
  assign stat_clr = (wr && (sel == GPIO_IRQ_STAT)) ? pin_bits : '0;

  iomem_gpio_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync [NUM_PINS-1:0] (
    .clk   (clk),
    .reset (reset),
    .d     (gpio_in),
    .q     (sync)
  );

  // Edge detection always compares the synchronised value with its own
  // delayed copy, so changing IRQ_POL alone can never fabricate an edge.
  always_comb begin
    rise     = sync & ~prev;
    fall     = ~sync & prev;
    edge_hit = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      edge_hit[i] = (irq_pol[i] == POL_RISE) ? rise[i] : fall[i];
    end
  end

  // Read mux over the pre-write register values; unused upper bits read 0.
  always_comb begin
    rd_pins = '0;
    case (sel)
      GPIO_OUT:      rd_pins = gpio_out;
      GPIO_OE:       rd_pins = gpio_oe;
      GPIO_IN:       rd_pins = sync;
      GPIO_IRQ_EN:   rd_pins = irq_en;
      GPIO_IRQ_STAT: rd_pins = irq_stat;
      GPIO_IRQ_POL:  rd_pins = irq_pol;
      default:       rd_pins = '0;
    endcase
    rd_word                = '0;
    rd_word[NUM_PINS-1:0]  = rd_pins;
  end

  // Bus acknowledge: one-cycle ready with read data registered alongside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ready <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ready <= hit;
      bus.rdata <= hit ? rd_word : '0;
    end
  end

  // Software-writable registers, including the OUT set/clear aliases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_out <= '0;
      gpio_oe  <= '0;
      irq_en   <= '0;
      irq_pol  <= '0;
    end else if (wr) begin
      case (sel)
        GPIO_OUT:     gpio_out <= merge(gpio_out, pin_mask, pin_bits);
        GPIO_OE:      gpio_oe  <= merge(gpio_oe,  pin_mask, pin_bits);
        GPIO_IRQ_EN:  irq_en   <= merge(irq_en,   pin_mask, pin_bits);
        GPIO_IRQ_POL: irq_pol  <= merge(irq_pol,  pin_mask, pin_bits);
        GPIO_OUT_SET: gpio_out <= gpio_out | pin_bits;
        GPIO_OUT_CLR: gpio_out <= gpio_out & ~pin_bits;
        default:      ;
      endcase
    end
  end

  // Sticky status (a new edge beats a same-cycle clear) and the IRQ line,
  // which follows status/enable one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev     <= '0;
      irq_stat <= '0;
      irq      <= 1'b0;
    end else begin
      prev     <= sync;
      irq_stat <= (irq_stat & ~stat_clr) | edge_hit;
      irq      <= |(irq_stat & irq_en);
    end
  end

endmodule
